// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM.
//
// Sequences the shared datapath through FETCH, DECODE and per-instruction
// execute / memory / write-back states. The opcode is captured in DECODE so
// that the instruction register may change without disturbing later states.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode[5:0]       instr[31:26] from the instruction register
//   mem_ready         memory access completes this cycle
//   gt                ALU greater-than result for bgt
//   alu_op[2:0]       ALU class code
//   pc_write          PC load enable
//   ir_write          instruction register load enable
//   mem_read          memory read strobe
//   mem_write         memory write strobe
//   iord              memory address select (0 = PC, 1 = ALUOut)
//   reg_write         register file write enable
//   reg_dst           write register select (1 = rd, 0 = rt)
//   mem_to_reg        write-back source (1 = MDR, 0 = ALUOut)
//   alu_src_a         ALU A select (0 = PC, 1 = rs)
//   alu_src_b[1:0]    ALU B select (rt, 4, sign-ext imm, imm<<2)
//   pc_src[1:0]       PC source (ALU, ALUOut, jump target)
//   state[3:0]        current state, for debug
//   illegal           one-cycle pulse on an unknown opcode in DECODE
module multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       gt,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [3:0] state,
  output logic       illegal
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRtExe  = 4'd6,
    StAluWb  = 4'd7,
    StImmExe = 4'd8,
    StBranch = 4'd9,
    StJump   = 4'd10
  } state_e;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpXori = 6'b001110;
  localparam logic [5:0] OpBgt  = 6'b000111;
  localparam logic [5:0] OpJ    = 6'b000010;

  state_e     r_state;
  state_e     w_state_next;
  logic [5:0] r_opcode;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StFetch;
      r_opcode <= 6'b000000;
    end else begin
      r_state <= w_state_next;
      if (r_state == StDecode) begin
        r_opcode <= opcode;
      end
    end
  end

  assign state = r_state;

  always_comb begin
    w_state_next = StFetch;  // also the recovery path for unused encodings
    alu_op       = 3'b000;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    illegal      = 1'b0;

    case (r_state)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        w_state_next = mem_ready ? StDecode : StFetch;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut; the live opcode is used
        // here because the latched copy only updates at the end of DECODE.
        alu_src_b = 2'b11;
        case (opcode)
          OpLw, OpSw:                    w_state_next = StMemAdr;
          OpR:                           w_state_next = StRtExe;
          OpAddi, OpAndi, OpOri, OpXori: w_state_next = StImmExe;
          OpBgt:                         w_state_next = StBranch;
          OpJ:                           w_state_next = StJump;
          default: begin
            illegal      = 1'b1;
            w_state_next = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = (r_opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_read     = 1'b1;
        iord         = 1'b1;
        w_state_next = mem_ready ? StMemWb : StMemRd;
      end
      StMemWb: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        w_state_next = StFetch;
      end
      StMemWr: begin
        mem_write    = 1'b1;
        iord         = 1'b1;
        w_state_next = mem_ready ? StFetch : StMemWr;
      end
      StRtExe: begin
        alu_src_a    = 1'b1;
        alu_op       = 3'b010;
        w_state_next = StAluWb;
      end
      StImmExe: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (r_opcode)
          OpAndi:  alu_op = 3'b011;
          OpXori:  alu_op = 3'b100;
          OpOri:   alu_op = 3'b101;
          default: alu_op = 3'b000;
        endcase
        w_state_next = StAluWb;
      end
      StAluWb: begin
        reg_write    = 1'b1;
        reg_dst      = (r_opcode == OpR);
        w_state_next = StFetch;
      end
      StBranch: begin
        alu_src_a    = 1'b1;
        alu_op       = 3'b001;
        pc_src       = 2'b01;
        pc_write     = gt;
        w_state_next = StFetch;
      end
      StJump: begin
        pc_write     = 1'b1;
        pc_src       = 2'b10;
        w_state_next = StFetch;
      end
      default: w_state_next = StFetch;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus process pushes the
// expected output vector for each driven cycle; the monitor pops and compares.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       gt;
  logic [2:0] alu_op;
  logic       pc_write, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic [3:0] state;
  logic       illegal;

  always #5 clk = ~clk;

  multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .gt        (gt),
    .alu_op    (alu_op),
    .pc_write  (pc_write),
    .ir_write  (ir_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .iord      (iord),
    .reg_write (reg_write),
    .reg_dst   (reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src_a (alu_src_a),
    .alu_src_b (alu_src_b),
    .pc_src    (pc_src),
    .state     (state),
    .illegal   (illegal)
  );

  typedef struct packed {
    logic [3:0] st;
    logic [2:0] aop;
    logic       pcw;
    logic       irw;
    logic       mrd;
    logic       mwr;
    logic       iord;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] pcsrc;
    logic       ill;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } sb_t;

  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpAndi = 6'b001100;
  localparam logic [5:0] OpOri  = 6'b001101;
  localparam logic [5:0] OpBgt  = 6'b000111;
  localparam logic [5:0] OpJ    = 6'b000010;
  localparam logic [5:0] OpBad  = 6'b111111;

  exp_t act;
  assign act = {state, alu_op, pc_write, ir_write, mem_read, mem_write, iord, reg_write,
                reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, illegal};

  sb_t sb[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  stim_done = 1'b0;

  // Expected output vectors per state, written straight from the state table.
  function automatic exp_t e_zero(input logic [3:0] st);
    exp_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction
  function automatic exp_t e_fetch(input logic mr);
    exp_t e;
    e = e_zero(4'd0); e.mrd = 1'b1; e.srcb = 2'b01; e.irw = mr; e.pcw = mr;
    return e;
  endfunction
  function automatic exp_t e_decode(input logic ill);
    exp_t e;
    e = e_zero(4'd1); e.srcb = 2'b11; e.ill = ill;
    return e;
  endfunction
  function automatic exp_t e_memadr();
    exp_t e;
    e = e_zero(4'd2); e.srca = 1'b1; e.srcb = 2'b10;
    return e;
  endfunction
  function automatic exp_t e_memrd();
    exp_t e;
    e = e_zero(4'd3); e.mrd = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_memwb();
    exp_t e;
    e = e_zero(4'd4); e.rw = 1'b1; e.m2r = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_memwr();
    exp_t e;
    e = e_zero(4'd5); e.mwr = 1'b1; e.iord = 1'b1;
    return e;
  endfunction
  function automatic exp_t e_rtexe();
    exp_t e;
    e = e_zero(4'd6); e.srca = 1'b1; e.aop = 3'b010;
    return e;
  endfunction
  function automatic exp_t e_aluwb(input logic rdst);
    exp_t e;
    e = e_zero(4'd7); e.rw = 1'b1; e.rdst = rdst;
    return e;
  endfunction
  function automatic exp_t e_immexe(input logic [2:0] aop);
    exp_t e;
    e = e_zero(4'd8); e.srca = 1'b1; e.srcb = 2'b10; e.aop = aop;
    return e;
  endfunction
  function automatic exp_t e_branch(input logic g);
    exp_t e;
    e = e_zero(4'd9); e.srca = 1'b1; e.aop = 3'b001; e.pcsrc = 2'b01; e.pcw = g;
    return e;
  endfunction
  function automatic exp_t e_jump();
    exp_t e;
    e = e_zero(4'd10); e.pcw = 1'b1; e.pcsrc = 2'b10;
    return e;
  endfunction

  // Drive one cycle of inputs and queue what the DUT must show in that cycle.
  task automatic cyc(input logic rst, input logic [5:0] op, input logic mr, input logic g,
                     input exp_t e, input string name);
    sb_t item;
    @(negedge clk);
    reset     = rst;
    opcode    = op;
    mem_ready = mr;
    gt        = g;
    item.e    = e;
    item.name = name;
    sb.push_back(item);
  endtask

  // Monitor: the FSM presents a full output vector every cycle.
  initial begin
    sb_t item;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        item = sb.pop_front();
        n_checks++;
        if (act === item.e) n_pass++;
        else $display("FAIL %s: got %h required %h (state %0d vs %0d)", item.name, act,
                      item.e, act.st, item.e.st);
      end
    end
  end

  initial begin
    reset = 1'b1; opcode = OpR; mem_ready = 1'b0; gt = 1'b0;
    @(posedge clk);
    // Second reset cycle: state already FETCH, no strobes without mem_ready.
    cyc(1'b1, OpR, 1'b0, 1'b0, e_fetch(1'b0), "reset_fetch");
    cyc(1'b0, OpR, 1'b0, 1'b0, e_fetch(1'b0), "post_reset_fetch");

    // lw, mem_ready tied high; opcode scrambled after DECODE to prove latching.
    cyc(1'b0, OpLw,  1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
    cyc(1'b0, OpLw,  1'b1, 1'b0, e_decode(1'b0), "lw_decode");
    cyc(1'b0, OpBad, 1'b1, 1'b0, e_memadr(), "lw_memadr");
    cyc(1'b0, OpBad, 1'b1, 1'b0, e_memrd(), "lw_memrd");
    cyc(1'b0, OpBad, 1'b1, 1'b0, e_memwb(), "lw_memwb");

    // sw with three wait cycles in MEMWR.
    cyc(1'b0, OpSw, 1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
    cyc(1'b0, OpSw, 1'b1, 1'b0, e_decode(1'b0), "sw_decode");
    cyc(1'b0, OpSw, 1'b1, 1'b0, e_memadr(), "sw_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, OpSw, 1'b0, 1'b0, e_memwr(), "sw_memwr_wait");
    cyc(1'b0, OpSw, 1'b1, 1'b0, e_memwr(), "sw_memwr_done");

    // R-type then ori, then andi.
    cyc(1'b0, OpR,    1'b1, 1'b0, e_fetch(1'b1), "r_fetch");
    cyc(1'b0, OpR,    1'b1, 1'b0, e_decode(1'b0), "r_decode");
    cyc(1'b0, OpR,    1'b1, 1'b0, e_rtexe(), "r_rtexe");
    cyc(1'b0, OpR,    1'b1, 1'b0, e_aluwb(1'b1), "r_aluwb");
    cyc(1'b0, OpOri,  1'b1, 1'b0, e_fetch(1'b1), "ori_fetch");
    cyc(1'b0, OpOri,  1'b1, 1'b0, e_decode(1'b0), "ori_decode");
    cyc(1'b0, OpOri,  1'b1, 1'b0, e_immexe(3'b101), "ori_immexe");
    cyc(1'b0, OpOri,  1'b1, 1'b0, e_aluwb(1'b0), "ori_aluwb");
    cyc(1'b0, OpAndi, 1'b1, 1'b0, e_fetch(1'b1), "andi_fetch");
    cyc(1'b0, OpAndi, 1'b1, 1'b0, e_decode(1'b0), "andi_decode");
    cyc(1'b0, OpAndi, 1'b1, 1'b0, e_immexe(3'b011), "andi_immexe");
    cyc(1'b0, OpAndi, 1'b1, 1'b0, e_aluwb(1'b0), "andi_aluwb");

    // bgt not taken, then taken.
    cyc(1'b0, OpBgt, 1'b1, 1'b0, e_fetch(1'b1), "bgt0_fetch");
    cyc(1'b0, OpBgt, 1'b1, 1'b0, e_decode(1'b0), "bgt0_decode");
    cyc(1'b0, OpBgt, 1'b1, 1'b0, e_branch(1'b0), "bgt0_branch");
    cyc(1'b0, OpBgt, 1'b1, 1'b0, e_fetch(1'b1), "bgt1_fetch");
    cyc(1'b0, OpBgt, 1'b1, 1'b1, e_decode(1'b0), "bgt1_decode");
    cyc(1'b0, OpBgt, 1'b1, 1'b1, e_branch(1'b1), "bgt1_branch");

    // j, with a FETCH wait cycle first.
    cyc(1'b0, OpJ, 1'b0, 1'b0, e_fetch(1'b0), "j_fetch_wait");
    cyc(1'b0, OpJ, 1'b1, 1'b0, e_fetch(1'b1), "j_fetch");
    cyc(1'b0, OpJ, 1'b1, 1'b0, e_decode(1'b0), "j_decode");
    cyc(1'b0, OpJ, 1'b1, 1'b0, e_jump(), "j_jump");

    // Unknown opcode: illegal pulse in DECODE, straight back to FETCH.
    cyc(1'b0, OpBad, 1'b1, 1'b0, e_fetch(1'b1), "bad_fetch");
    cyc(1'b0, OpBad, 1'b1, 1'b0, e_decode(1'b1), "bad_decode");
    cyc(1'b0, OpBad, 1'b0, 1'b0, e_fetch(1'b0), "bad_next_fetch");

    // Reset while waiting in MEMRD.
    cyc(1'b0, OpLw, 1'b1, 1'b0, e_fetch(1'b1), "rst_lw_fetch");
    cyc(1'b0, OpLw, 1'b1, 1'b0, e_decode(1'b0), "rst_lw_decode");
    cyc(1'b0, OpLw, 1'b1, 1'b0, e_memadr(), "rst_lw_memadr");
    cyc(1'b0, OpLw, 1'b0, 1'b0, e_memrd(), "rst_lw_memrd_wait");
    cyc(1'b1, OpLw, 1'b0, 1'b0, e_memrd(), "rst_in_memrd");
    cyc(1'b0, OpLw, 1'b0, 1'b0, e_fetch(1'b0), "after_rst_fetch");
    cyc(1'b0, OpLw, 1'b1, 1'b0, e_fetch(1'b1), "after_rst_fetch_rdy");
    cyc(1'b0, OpLw, 1'b1, 1'b0, e_decode(1'b0), "after_rst_decode");

    // Give the monitor time to drain; an undrained queue is a failure.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #4;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d entries left required 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk is the single clock; reset is synchronous and active-high.
REQ-002 The ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-high reset.
- opcode  in  6  instr[31:26] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory access completes this cycle.
- gt  in  1  ALU "greater-than" result for bgt.
- alu_op  out  3  ALU class code to the ALU control decoder.
- pc_write  out  1  unconditional PC load.
- ir_write  out  1  load the instruction register.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  write register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back source: 1 = MDR, 0 = ALUOut.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
- alu_src_b  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- pc_src  out  2  PC source select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- state  out  4  current state, for debug.
- illegal  out  1  one-cycle pulse on an unknown opcode.

Function
REQ-003 alu_op encoding SHALL be: 000 add; 001 bgt compare/subtract; 010 R-type (funct decoded downstream); 011 andi; 100 xori; 101 ori.
REQ-004 Decoded opcodes SHALL be: R 000000, lw 100011, sw 101011, addi 001000, andi 001100, ori 001101, xori 001110, bgt 000111, j 000010.
REQ-005 The state encoding SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, ALUWB 7, IMMEXE 8, BRANCH 9, JUMP 10; values 11-15 SHALL never be reached.
REQ-006 opcode SHALL be latched into an internal register in DECODE; all later states SHALL decode from the latched copy.
REQ-007 Any output not listed for a state SHALL be 0 in that state; alu_op SHALL default to 000.
REQ-008 FETCH SHALL assert mem_read, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000 and pc_src=00.
REQ-009 FETCH SHALL assert ir_write and pc_write only in a cycle with mem_ready=1, and SHALL then go to DECODE; with mem_ready=0 it SHALL stay in FETCH.
REQ-010 DECODE SHALL assert alu_src_a=0, alu_src_b=11 and alu_op=000 (branch target into ALUOut), and SHALL last exactly 1 cycle.
REQ-011 DECODE next state SHALL be: lw/sw -> MEMADR; R -> RTEXE; addi/andi/ori/xori -> IMMEXE; bgt -> BRANCH; j -> JUMP; any other opcode -> FETCH with illegal=1 for that cycle.
REQ-012 MEMADR SHALL assert alu_src_a=1, alu_src_b=10 and alu_op=000, then go to MEMRD for lw or MEMWR for sw.
REQ-013 MEMRD SHALL assert mem_read and iord=1, and SHALL hold until mem_ready=1, then go to MEMWB.
REQ-014 MEMWB SHALL assert reg_write, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-015 MEMWR SHALL assert mem_write and iord=1, and SHALL hold until mem_ready=1, then go to FETCH; mem_write SHALL stay high while held.
REQ-016 RTEXE SHALL assert alu_src_a=1, alu_src_b=00 and alu_op=010, then go to ALUWB.
REQ-017 IMMEXE SHALL assert alu_src_a=1 and alu_src_b=10, with alu_op = addi 000, andi 011, xori 100, ori 101; it SHALL then go to ALUWB.
REQ-018 ALUWB SHALL assert reg_write and mem_to_reg=0, with reg_dst=1 if the latched opcode is R-type else 0, then go to FETCH.
REQ-019 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=001 and pc_src=01, and SHALL assert pc_write only when gt=1 in that cycle; it SHALL then go to FETCH.
REQ-020 JUMP SHALL assert pc_write and pc_src=10, then go to FETCH.
REQ-021 Latency in cycles, excluding memory wait states, SHALL be: lw 5, sw 4, R-type/imm 4, bgt 3, j 3.
REQ-022 If the FSM somehow reaches an unreachable state it SHALL recover to FETCH on the next edge.

Reset
REQ-023 When reset=1 at a rising edge, state SHALL become FETCH and the latched opcode SHALL become 000000, overriding any transition including mid-wait in MEMRD/MEMWR.
REQ-024 During the reset cycle the outputs SHALL be the combinational decode of the current state; the cycle after reset SHALL present FETCH outputs with no pc_write/ir_write unless mem_ready=1.
REQ-025 illegal SHALL be 0 in the cycle after reset.

Verification
REQ-026 The bench SHALL cover lw with mem_ready tied to 1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in state 4; alu_op=000 throughout.
REQ-027 The bench SHALL cover sw with mem_ready=0 for 3 cycles in MEMWR -> state 5 held for 4 cycles with mem_write=1, then FETCH; reg_write is never asserted.
REQ-028 The bench SHALL cover R-type then ori -> alu_op=010 in RTEXE with reg_dst=1 in ALUWB; alu_op=101 in IMMEXE with reg_dst=0.
REQ-029 The bench SHALL cover bgt with gt=0 and then with gt=1 -> alu_op=001 and pc_src=01 in BRANCH; pc_write is 0 for gt=0 and 1 for gt=1.
REQ-030 The bench SHALL cover opcode 111111 -> illegal=1 for one cycle in DECODE, next state FETCH, no write strobes asserted.
REQ-031 The bench SHALL cover reset asserted while held in MEMRD -> state=0 on the next edge, mem_read driven by FETCH decode (iord=0).
